// File: rtl/axis_channel_selector.sv
// AXI-Stream N:1 channel selector with frame-safe switching and a single
// registered output stage. Unselected channels are either drained or stalled.
module axis_channel_selector #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 4,
    parameter int SEL_WIDTH   = 2,
    parameter int DRAIN_UNSEL = 1
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [SEL_WIDTH-1:0]         cfg,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    input  logic [NUM_CH-1:0]            s_axis_tlast,
    output logic [NUM_CH-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [SEL_WIDTH-1:0]         cur_sel,
    output logic                         switch_pending
);

    typedef enum logic {
        RUN    = 1'b0,
        SWITCH = 1'b1
    } state_t;

    localparam logic DRAIN_BIT = (DRAIN_UNSEL != 0);

    state_t                state_r;
    logic [SEL_WIDTH-1:0]  sel_r;
    logic [SEL_WIDTH-1:0]  pend_sel_r;
    logic [SEL_WIDTH-1:0]  cur_sel_r;
    logic                  in_frame_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  last_r;
    logic                  valid_r;

    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                  sel_last_s;
    logic                  sel_valid_s;
    logic                  out_free_s;
    logic                  cfg_valid_s;
    logic                  accept_s;
    logic [NUM_CH-1:0]     tready_s;

    assign out_free_s  = !valid_r || m_axis_tready;
    assign cfg_valid_s = (int'(cfg) < NUM_CH);
    assign accept_s    = (state_r == RUN) && !areset && sel_valid_s && out_free_s;

    // Route the active channel's beat to the output register input.
    always_comb begin
        sel_data_s  = {DATA_WIDTH{1'b0}};
        sel_last_s  = 1'b0;
        sel_valid_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_data_s  = (sel_r == SEL_WIDTH'(k)) ? s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
            sel_last_s  = (sel_r == SEL_WIDTH'(k)) ? s_axis_tlast[k]  : sel_last_s;
            sel_valid_s = (sel_r == SEL_WIDTH'(k)) ? s_axis_tvalid[k] : sel_valid_s;
        end
    end

    // Per-channel ready: old and new channel are both held off during the switch cycle.
    always_comb begin
        tready_s = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (areset) begin
                tready_s[k] = 1'b0;
            end else if (state_r == RUN) begin
                tready_s[k] = (sel_r == SEL_WIDTH'(k)) ? out_free_s : DRAIN_BIT;
            end else begin
                tready_s[k] = ((sel_r == SEL_WIDTH'(k)) || (pend_sel_r == SEL_WIDTH'(k))) ? 1'b0 : DRAIN_BIT;
            end
        end
    end

    // Output stage, frame tracking and the RUN/SWITCH controller.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= RUN;
            sel_r      <= {SEL_WIDTH{1'b0}};
            pend_sel_r <= {SEL_WIDTH{1'b0}};
            cur_sel_r  <= {SEL_WIDTH{1'b0}};
            in_frame_r <= 1'b0;
            data_r     <= {DATA_WIDTH{1'b0}};
            last_r     <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                data_r     <= sel_data_s;
                last_r     <= sel_last_s;
                valid_r    <= 1'b1;
                in_frame_r <= !sel_last_s;
            end else if (m_axis_tready) begin
                valid_r <= 1'b0;
            end
            case (state_r)
                RUN: begin
                    // A beat accepted this cycle (even a tlast) defers the switch decision.
                    if (cfg_valid_s && (cfg != sel_r) && !in_frame_r && !accept_s) begin
                        pend_sel_r <= cfg;
                        state_r    <= SWITCH;
                    end
                end
                SWITCH: begin
                    sel_r     <= pend_sel_r;
                    cur_sel_r <= pend_sel_r;
                    state_r   <= RUN;
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

    assign s_axis_tready  = tready_s;
    assign m_axis_tdata   = data_r;
    assign m_axis_tlast   = last_r;
    assign m_axis_tvalid  = valid_r;
    assign cur_sel        = cur_sel_r;
    assign switch_pending = cfg_valid_s && (cfg != cur_sel_r);

endmodule
